// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter: boundary-mode encoding and the
// helper that sizes the prescaler phase register.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Bits needed to hold 0..prescale-1, never less than one bit so the
    // phase register still exists when the prescaler is a pass-through.
    function automatic int presc_width(input int prescale);
        if (prescale <= 2) begin
            return 1;
        end
        return $clog2(prescale);
    endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Enable divider: produces a one-cycle tick on every PRESCALE-th enabled
// cycle. The phase only moves while en is high, so pausing en holds it.
module cnt_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = presc_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    assign tick = en && (phase == LAST);

    // Phase register: cleared by reset or clr, otherwise advances and wraps on enabled cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= (phase == LAST) ? '0 : phase + 1'b1;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Up/down counter over 0..MAX with wrap or saturate behaviour at the ends,
// a prescaled step enable, a one-cycle terminal-count pulse and a sticky
// boundary flag. All outputs come straight from registers.
module mod_counter
    import counter_pkg::*;
#(
    parameter int        WIDTH    = 16,
    parameter int        MAX      = 2**WIDTH - 1,
    parameter cnt_mode_e MODE     = CNT_WRAP,
    parameter int        PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] dout,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic             tick;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] dout_next;
    logic             tc_next;
    logic             ovf_next;

    // Both clr and load restart the step phase so the next step needs a full
    // PRESCALE run of enabled cycles.
    cnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr | load),
        .en    (en),
        .tick  (tick)
    );

    assign at_max  = (dout == MAX_V);
    assign at_zero = (dout == '0);

    // Next-state selection in priority order clr > load > step > hold; a boundary step sets ovf even if ovf_clr is high.
    always_comb begin
        dout_next = dout;
        tc_next   = 1'b0;
        ovf_next  = ovf & ~ovf_clr;
        if (clr) begin
            dout_next = '0;
            ovf_next  = 1'b0;
        end else if (load) begin
            dout_next = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (tick) begin
            if (up) begin
                if (at_max) begin
                    dout_next = (MODE == CNT_WRAP) ? '0 : MAX_V;
                    tc_next   = 1'b1;
                    ovf_next  = 1'b1;
                end else begin
                    dout_next = dout + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    dout_next = (MODE == CNT_WRAP) ? MAX_V : '0;
                    tc_next   = 1'b1;
                    ovf_next  = 1'b1;
                end else begin
                    dout_next = dout - 1'b1;
                end
            end
        end
    end

    // Output registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout <= '0;
            tc   <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            dout <= dout_next;
            tc   <= tc_next;
            ovf  <= ovf_next;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter. Three instances (wrap, saturate, and
// wrap with PRESCALE=3) share one stimulus bus; each expected entry names the
// instance it applies to and every section starts with a reset.
module tb_mod_counter;
    import counter_pkg::*;

    typedef struct {
        int         sel;
        logic [3:0] dout;
        logic       tc;
        logic       ovf;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       ovf_clr = 1'b0;

    logic [3:0] dout0, dout1, dout2;
    logic       tc0, tc1, tc2;
    logic       ovf0, ovf1, ovf2;

    mod_counter #(.WIDTH(4), .MAX(9), .MODE(CNT_WRAP), .PRESCALE(1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .dout(dout0), .tc(tc0), .ovf(ovf0)
    );

    mod_counter #(.WIDTH(4), .MAX(9), .MODE(CNT_SAT), .PRESCALE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .dout(dout1), .tc(tc1), .ovf(ovf1)
    );

    mod_counter #(.WIDTH(4), .MAX(9), .MODE(CNT_WRAP), .PRESCALE(3)) dut_pre (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .dout(dout2), .tc(tc2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, queue what the chosen instance must show after the edge.
    task automatic applyStimulus(input int sel, input logic r, input logic c, input logic e,
                                 input logic u, input logic l, input logic [3:0] lv,
                                 input logic oc, input logic [3:0] xd, input logic xt,
                                 input logic xo, input string nm);
        exp_t ent;
        rst_n    = r;
        clr      = c;
        en       = e;
        up       = u;
        load     = l;
        load_val = lv;
        ovf_clr  = oc;
        ent.sel  = sel;
        ent.dout = xd;
        ent.tc   = xt;
        ent.ovf  = xo;
        ent.name = nm;
        sb.push_back(ent);
        @(posedge clk);
        #2;
    endtask

    // Compare the selected instance against one scoreboard entry.
    task automatic checkOutput(input exp_t ent);
        logic [3:0] ad;
        logic       at;
        logic       ao;
        case (ent.sel)
            0:       begin ad = dout0; at = tc0; ao = ovf0; end
            1:       begin ad = dout1; at = tc1; ao = ovf1; end
            default: begin ad = dout2; at = tc2; ao = ovf2; end
        endcase
        checks++;
        if (ad !== ent.dout || at !== ent.tc || ao !== ent.ovf) begin
            failures++;
            $display("[TB] FAIL %s (dut%0d): got dout=%0d tc=%b ovf=%b, expected dout=%0d tc=%b ovf=%b",
                     ent.name, ent.sel, ad, at, ao, ent.dout, ent.tc, ent.ovf);
        end
    endtask

    // Monitor: just after every rising edge, pop the pending expectation and compare.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                checkOutput(sb.pop_front());
            end
        end
    end

    initial begin
        // ---- wrap instance, PRESCALE=1 ----
        applyStimulus(0, 0, 0, 1, 1, 0, 4'd0, 0, 4'd0, 0, 0, "wrap_reset");
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(0, 1, 0, 1, 1, 0, 4'd0, 0, 4'(i), 0, 0, "wrap_count_up");
        end
        applyStimulus(0, 1, 0, 1, 1, 0, 4'd0, 0, 4'd0, 1, 1, "wrap_roll_over");
        applyStimulus(0, 1, 0, 1, 1, 0, 4'd0, 0, 4'd1, 0, 1, "wrap_after_roll");
        applyStimulus(0, 1, 0, 0, 1, 1, 4'd0, 0, 4'd0, 0, 1, "load_keeps_ovf");
        applyStimulus(0, 1, 0, 0, 1, 0, 4'd0, 1, 4'd0, 0, 0, "ovf_clr_alone");
        applyStimulus(0, 1, 0, 1, 0, 0, 4'd0, 0, 4'd9, 1, 1, "wrap_down_from_zero");
        applyStimulus(0, 1, 0, 1, 0, 0, 4'd0, 0, 4'd8, 0, 1, "count_down");
        applyStimulus(0, 1, 0, 0, 0, 1, 4'd0, 0, 4'd0, 0, 1, "load_zero");
        applyStimulus(0, 1, 0, 1, 0, 0, 4'd0, 1, 4'd9, 1, 1, "ovf_set_beats_clr");
        applyStimulus(0, 1, 0, 0, 0, 0, 4'd0, 1, 4'd9, 0, 0, "ovf_clr_hold");
        applyStimulus(0, 1, 0, 1, 1, 1, 4'd15, 0, 4'd9, 0, 0, "load_clamped");
        applyStimulus(0, 1, 1, 1, 1, 1, 4'd5, 0, 4'd0, 0, 0, "clr_beats_load");
        applyStimulus(0, 1, 0, 1, 1, 1, 4'd3, 0, 4'd3, 0, 0, "load_three");
        applyStimulus(0, 1, 0, 0, 1, 0, 4'd0, 0, 4'd3, 0, 0, "en_low_freeze");
        applyStimulus(0, 1, 0, 0, 1, 1, 4'd9, 0, 4'd9, 0, 0, "load_max");
        applyStimulus(0, 1, 0, 1, 1, 0, 4'd0, 0, 4'd0, 1, 1, "wrap_again");
        applyStimulus(0, 1, 0, 1, 1, 0, 4'd0, 0, 4'd1, 0, 1, "tc_one_cycle");
        applyStimulus(0, 1, 1, 1, 1, 0, 4'd0, 0, 4'd0, 0, 0, "clr_clears_ovf");
        applyStimulus(0, 1, 0, 1, 1, 1, 4'd9, 0, 4'd9, 0, 0, "load_max_2");
        applyStimulus(0, 1, 0, 1, 1, 0, 4'd0, 0, 4'd0, 1, 1, "wrap_third");
        applyStimulus(0, 1, 0, 0, 1, 1, 4'd5, 0, 4'd5, 0, 1, "load_five");
        applyStimulus(0, 0, 0, 1, 1, 0, 4'd0, 0, 4'd0, 0, 0, "reset_mid_count");
        applyStimulus(0, 1, 0, 1, 1, 0, 4'd0, 0, 4'd1, 0, 0, "resume_after_reset");

        // ---- saturating instance, PRESCALE=1 ----
        applyStimulus(1, 0, 0, 0, 1, 0, 4'd0, 0, 4'd0, 0, 0, "sat_reset");
        applyStimulus(1, 1, 0, 0, 1, 1, 4'd8, 0, 4'd8, 0, 0, "sat_load_eight");
        applyStimulus(1, 1, 0, 1, 1, 0, 4'd0, 0, 4'd9, 0, 0, "sat_step1");
        applyStimulus(1, 1, 0, 1, 1, 0, 4'd0, 0, 4'd9, 1, 1, "sat_step2");
        applyStimulus(1, 1, 0, 1, 1, 0, 4'd0, 0, 4'd9, 1, 1, "sat_step3");
        applyStimulus(1, 1, 0, 1, 0, 0, 4'd0, 0, 4'd8, 0, 1, "sat_step_down");
        applyStimulus(1, 1, 0, 0, 0, 1, 4'd0, 0, 4'd0, 0, 1, "sat_load_zero");
        applyStimulus(1, 1, 0, 1, 0, 0, 4'd0, 0, 4'd0, 1, 1, "sat_hold_zero");
        applyStimulus(1, 1, 0, 0, 0, 0, 4'd0, 1, 4'd0, 0, 0, "sat_ovf_clr");

        // ---- wrap instance, PRESCALE=3 ----
        applyStimulus(2, 0, 0, 0, 1, 0, 4'd0, 0, 4'd0, 0, 0, "pre_reset");
        applyStimulus(2, 1, 0, 1, 1, 0, 4'd0, 0, 4'd0, 0, 0, "pre_phase1");
        applyStimulus(2, 1, 0, 1, 1, 0, 4'd0, 0, 4'd0, 0, 0, "pre_phase2");
        applyStimulus(2, 1, 0, 1, 1, 0, 4'd0, 0, 4'd1, 0, 0, "pre_step1");
        applyStimulus(2, 1, 0, 1, 1, 0, 4'd0, 0, 4'd1, 0, 0, "pre_wait_a");
        applyStimulus(2, 1, 0, 1, 1, 0, 4'd0, 0, 4'd1, 0, 0, "pre_wait_b");
        applyStimulus(2, 1, 0, 1, 1, 0, 4'd0, 0, 4'd2, 0, 0, "pre_step2");
        applyStimulus(2, 1, 0, 1, 1, 0, 4'd0, 0, 4'd2, 0, 0, "pre_phase_one");
        applyStimulus(2, 1, 0, 0, 1, 0, 4'd0, 0, 4'd2, 0, 0, "pre_paused_a");
        applyStimulus(2, 1, 0, 0, 1, 0, 4'd0, 0, 4'd2, 0, 0, "pre_paused_b");
        applyStimulus(2, 1, 0, 1, 1, 0, 4'd0, 0, 4'd2, 0, 0, "pre_phase_two");
        applyStimulus(2, 1, 0, 1, 1, 0, 4'd0, 0, 4'd3, 0, 0, "pre_delayed_step");
        applyStimulus(2, 1, 0, 1, 0, 0, 4'd0, 0, 4'd3, 0, 0, "pre_dir_a");
        applyStimulus(2, 1, 0, 1, 0, 0, 4'd0, 0, 4'd3, 0, 0, "pre_dir_b");
        applyStimulus(2, 1, 0, 1, 0, 0, 4'd0, 0, 4'd2, 0, 0, "pre_dir_step");
        applyStimulus(2, 1, 0, 1, 1, 0, 4'd0, 0, 4'd2, 0, 0, "pre_pend_a");
        applyStimulus(2, 1, 0, 1, 1, 0, 4'd0, 0, 4'd2, 0, 0, "pre_pend_b");
        applyStimulus(2, 0, 0, 1, 1, 0, 4'd0, 0, 4'd0, 0, 0, "pre_reset_discard");
        applyStimulus(2, 1, 0, 1, 1, 0, 4'd0, 0, 4'd0, 0, 0, "pre_fresh_a");
        applyStimulus(2, 1, 0, 1, 1, 0, 4'd0, 0, 4'd0, 0, 0, "pre_fresh_b");
        applyStimulus(2, 1, 0, 1, 1, 0, 4'd0, 0, 4'd1, 0, 0, "pre_fresh_step");

        en = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
